// File: rtl/div_pkg.sv
// Shared definitions for the multicycle signed divider: FSM states and sizing.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = DIV_WIDTH;
  localparam int DIV_CNT_W = $clog2(DIV_ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division step on unsigned magnitudes: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // When the subtraction succeeds the true difference is below divisor, so modulo-2^WIDTH is exact.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    ge       = (shifted >= {1'b0, divisor});
    diff     = shifted[WIDTH-1:0] - divisor;
    rem_next = ge ? diff : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div.sv
// Multicycle signed divider (MIPS DIV): quotient to lo, remainder to hi, one quotient bit per clock.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic                    div_control,
  output logic signed [WIDTH-1:0] hi,
  output logic signed [WIDTH-1:0] lo,
  output logic                    operando,
  output logic                    div_done,
  output logic                    div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             sign_q;
  logic             sign_r;

  // Magnitude as unsigned; the most negative value maps onto itself, which is correct unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m, input logic neg);
    return neg ? (~m + 1'b1) : m;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvsr),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      operando <= 1'b0;
      div_done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_done <= 1'b0;
          if (div_control) begin
            operando <= 1'b1;
            div_zero <= (y == '0);
            dvsr     <= mag(y);
            quo      <= mag(x);
            rem      <= '0;
            sign_q   <= x[WIDTH-1] ^ y[WIDTH-1];
            sign_r   <= x[WIDTH-1];
            count    <= CNT_W'(WIDTH);
            state    <= (y == '0) ? FIX : RUN;
          end
        end
        RUN: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count - 1'b1;
          if (count == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          // A zero divisor leaves the previous result in place.
          if (!div_zero) begin
            lo <= apply_sign(quo, sign_q);
            hi <= apply_sign(rem, sign_r);
          end
          operando <= 1'b0;
          div_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Bench for div: arithmetic reference model with cycle-level busy tracking, plus directed literal checks.
module tb_div;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        div_control = 1'b0;
  logic [31:0] hi, lo;
  logic        operando, div_done, div_zero;

  int checks = 0;
  int errors = 0;

  div #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .div_control (div_control),
    .hi          (hi),
    .lo          (lo),
    .operando    (operando),
    .div_done    (div_done),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Reference model: an accepted op stays busy for 33 edges (1 when y==0), then publishes its result.
  logic [31:0] m_hi = '0, m_lo = '0, p_q = '0, p_r = '0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b0;
  int          remaining = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_zero = 0; remaining = 0;
    end else begin
      m_done = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          if (!m_zero) begin
            m_hi = p_r;
            m_lo = p_q;
          end
        end
      end else if (div_control) begin
        m_busy = 1'b1;
        m_zero = (y == 0);
        remaining = m_zero ? 1 : 33;
        if (!m_zero) ref_div(x, y, p_q, p_r);
      end
    end
  end

  always @(negedge clk) begin
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("operando", 32'(operando), 32'(m_busy));
    chk("div_done", 32'(div_done), 32'(m_done));
    chk("div_zero", 32'(div_zero), 32'(m_zero));
  end

  // Single-cycle start, then wait (bounded) for the done pulse; returns busy cycles seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int busy);
    bit seen = 0;
    busy = 0;
    @(negedge clk);
    x = a; y = b; div_control = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      div_control = 1'b0;
      if (operando) busy++;
      if (div_done) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout actual=no_done required=done x=%h y=%h", a, b);
    end
  endtask

  typedef struct { logic [31:0] a, b, q, r; } vec_t;
  vec_t vecs[4] = '{
    '{32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF},
    '{32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1},
    '{32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0},
    '{32'h7FFF_FFFF, 32'd1,          32'h7FFF_FFFF, 32'd0}
  };

  initial begin
    int busy;
    int pulses;
    bit seen;

    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_operando", 32'(operando), 32'd0);
    reset = 1'b1;

    // T1
    run_op(32'd100, 32'd7, busy);
    chk("t1_lo", lo, 32'd14);
    chk("t1_hi", hi, 32'd2);
    chk("t1_busy_cycles", busy, 32'd33);
    @(negedge clk);
    chk("t1_done_cleared", 32'(div_done), 32'd0);

    // T2, T3
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, busy);
      chk("t23_lo", lo, vecs[i].q);
      chk("t23_hi", hi, vecs[i].r);
    end

    // T4
    run_op(32'd100, 32'd7, busy);
    run_op(32'd5, 32'd0, busy);
    chk("t4_zero", 32'(div_zero), 32'd1);
    chk("t4_busy_cycles", busy, 32'd1);
    chk("t4_hi_kept", hi, 32'd2);
    chk("t4_lo_kept", lo, 32'd14);
    run_op(32'd9, 32'd3, busy);
    chk("t4_zero_clr", 32'(div_zero), 32'd0);
    chk("t4_lo", lo, 32'd3);
    chk("t4_hi", hi, 32'd0);

    // T5: start, then toggle control and scramble operands mid-run
    @(negedge clk);
    x = 32'd1000; y = 32'd10; div_control = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      div_control = ~div_control;
      x = $urandom; y = $urandom;
    end
    div_control = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_done) pulses++;
    end
    chk("t5_lo", lo, 32'd100);
    chk("t5_hi", hi, 32'd0);
    chk("t5_pulses", pulses, 32'd1);

    // Back-to-back: control held high across the result edge starts the next op
    @(negedge clk);
    x = 32'd100; y = 32'd7; div_control = 1'b1;
    @(negedge clk);
    x = 32'hFFFF_FFCE; y = 32'd3;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = div_done;
    end
    chk("b2b_first_lo", lo, 32'd14);
    @(negedge clk);
    div_control = 1'b0;
    chk("b2b_restart", 32'(operando), 32'd1);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = div_done;
    end
    chk("b2b_lo", lo, 32'hFFFF_FFF0);
    chk("b2b_hi", hi, 32'hFFFF_FFFE);

    // T6: asynchronous reset in the middle of the run
    @(negedge clk);
    x = 32'd77; y = 32'd5; div_control = 1'b1;
    @(posedge clk);
    #1 div_control = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_hi", hi, 32'd0);
    chk("t6_lo", lo, 32'd0);
    chk("t6_operando", 32'(operando), 32'd0);
    chk("t6_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(32'd9, 32'd4, busy);
    chk("t6_lo_after", lo, 32'd2);
    chk("t6_hi_after", hi, 32'd1);

    // Random signed pairs, checked by the model every cycle
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (n % 4 == 1) b = $urandom_range(1, 20);
      if (n % 4 == 2) b = -$urandom_range(1, 20);
      if (b == 0) b = 32'd1;
      run_op(a, b, busy);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
